// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, captures instruction words into an
// in-order queue for decode, and handles branch redirects and misaligned-target halts.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        misalign_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          err_q, err_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic push;
    logic pop;
    logic redir;
    logic misal;

    always_comb begin
        pop   = (count_q != '0) && out_ready;
        // A full queue still accepts a new word when the head leaves in the same cycle.
        push  = (state_q == FETCH) && fetch_en && !redirect_valid && ((count_q < FULL) || pop);
        redir = redirect_valid && (state_q != HALT);
        misal = redir && (redirect_pc[1:0] != 2'b00);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q;

        case (state_q)
            IDLE:    if (fetch_en)  state_d = FETCH;
            FETCH:   if (!fetch_en) state_d = IDLE;
            default: state_d = HALT;
        endcase

        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

        // Redirect discards everything queued, including any same-cycle handshake.
        if (redir) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (misal) begin
                state_d = HALT;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

    assign imem_addr    = fetch_pc_q;
    assign out_valid    = (count_q != '0);
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_instr    = instr_mem_q[rd_ptr_q];
    assign misalign_err = err_q;

endmodule
